// File: rtl/wave_pixel_modulator.sv
// Pixel stage around horizontal_wave: emits per-pixel x/phase, delays each pixel to
// meet the returned Q1.15 coefficient, then scales the R, G and B channels by it.
module wave_pixel_modulator #(
  parameter int unsigned WAVE_LATENCY = 13,
  parameter int unsigned CH_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [15:0]             phase_step,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [3*CH_WIDTH-1:0]   s_data,
  input  logic                    s_user,
  input  logic                    s_last,
  output logic                    wave_en,
  output logic [15:0]             wave_x,
  output logic [15:0]             wave_phase,
  input  logic [15:0]             wave_koef,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [3*CH_WIDTH-1:0]   m_data,
  output logic                    m_user,
  output logic                    m_last
);

  localparam int unsigned DW = 3 * CH_WIDTH;
  localparam int unsigned SW = DW + 3;
  localparam int unsigned PW = CH_WIDTH + 18;

  logic             advance;
  logic             accept;
  logic             sof_step;
  logic [15:0]      x_q;
  logic [15:0]      phase_acc_q;
  logic             first_frame_q;
  logic [SW-1:0]    dl_q [WAVE_LATENCY];
  logic [SW-1:0]    head;
  logic [DW-1:0]    scaled_d;
  logic             m_valid_q;
  logic [DW-1:0]    m_data_q;
  logic             m_user_q;
  logic             m_last_q;

  assign advance = en & (m_ready | ~m_valid_q);
  assign accept  = s_valid & advance;
  assign s_ready = advance;
  assign wave_en = advance;
  assign head    = dl_q[WAVE_LATENCY-1];

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_user  = m_user_q;
  assign m_last  = m_last_q;

  // The very first SOF after reset keeps phase 0; later SOFs see the stepped phase at once.
  always_comb begin
    wave_x     = s_user ? '0 : x_q;
    sof_step   = s_valid & s_user & ~first_frame_q;
    wave_phase = sof_step ? phase_acc_q + phase_step : phase_acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      phase_acc_q   <= '0;
      first_frame_q <= 1'b1;
    end else if (accept) begin
      x_q <= s_last ? '0 : wave_x + 16'd1;
      if (s_user) begin
        if (first_frame_q) first_frame_q <= 1'b0;
        else               phase_acc_q   <= wave_phase;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WAVE_LATENCY; i++) dl_q[i] <= '0;
    end else if (advance) begin
      dl_q[0] <= {accept, s_data, s_user, s_last};
      for (int unsigned i = 1; i < WAVE_LATENCY; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  function automatic logic [CH_WIDTH-1:0] scale_ch(input logic [CH_WIDTH-1:0] ch,
                                                    input logic [15:0] k);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    p = $signed({{(PW-CH_WIDTH){1'b0}}, ch}) * $signed({{(PW-16){k[15]}}, k});
    r = (p + $signed(PW'(16384))) >>> 15;
    if (k[15])                     return '0;
    else if (|r[PW-1:CH_WIDTH])    return '1;
    else                           return r[CH_WIDTH-1:0];
  endfunction

  always_comb begin
    scaled_d = '0;
    for (int unsigned c = 0; c < 3; c++)
      scaled_d[c*CH_WIDTH +: CH_WIDTH] = scale_ch(head[2 + c*CH_WIDTH +: CH_WIDTH], wave_koef);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (advance) begin
      m_valid_q <= head[SW-1];
      m_data_q  <= scaled_d;
      m_user_q  <= head[1];
      m_last_q  <= head[0];
    end
  end

endmodule

// File: tb/tb_wave_pixel_modulator.sv
// Directed and randomized checks of wave_pixel_modulator against a delay-line wave model.
module tb_wave_pixel_modulator;

  localparam int L  = 13;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [15:0]  phase_step = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [23:0]  s_data = '0;
  logic         s_user = 1'b0;
  logic         s_last = 1'b0;
  logic         wave_en;
  logic [15:0]  wave_x;
  logic [15:0]  wave_phase;
  logic [15:0]  wave_koef;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [23:0]  m_data;
  logic         m_user;
  logic         m_last;

  logic [15:0]  stim_koef = '0;
  logic [15:0]  kp [L];

  wave_pixel_modulator #(.WAVE_LATENCY(L), .CH_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_step(phase_step),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_user(s_user), .s_last(s_last),
    .wave_en(wave_en), .wave_x(wave_x), .wave_phase(wave_phase), .wave_koef(wave_koef),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user), .m_last(m_last)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < L; i++) kp[i] = '0;

  always @(posedge clk) begin
    if (wave_en) begin
      kp[0] <= stim_koef;
      for (int i = 1; i < L; i++) kp[i] <= kp[i-1];
    end
  end
  assign wave_koef = kp[L-1];

  int errors = 0;
  int checks = 0;
  logic [25:0] exp_q[$];
  logic [15:0] xlog[$];
  logic [15:0] phlog[$];
  logic        stall_p = 1'b0;
  logic [25:0] stall_v = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] ref_scale(input logic [23:0] px, input logic [15:0] k);
    int ki;
    int ch;
    int v;
    logic [23:0] o;
    o  = '0;
    ki = int'($signed(k));
    if (ki < 0) return '0;
    for (int c = 0; c < 3; c++) begin
      ch = int'(px[c*8 +: 8]);
      v  = (ch * ki + 16384) / 32768;
      if (v > 255) v = 255;
      o[c*8 +: 8] = v[7:0];
    end
    return o;
  endfunction

  task automatic cycle(input logic v, input logic [23:0] d, input logic u, input logic l,
                       input logic [15:0] k, input logic mr, input logic e,
                       input logic [23:0] expd);
    s_valid = v; s_data = d; s_user = u; s_last = l; stim_koef = k; m_ready = mr; en = e;
    #1;
    if (!e) check("s_ready_en0", {31'd0, s_ready}, 32'd0);
    if (stall_p) check("stall_hold", {5'd0, m_valid, m_data, m_user, m_last}, {5'd0, 1'b1, stall_v});
    stall_p = m_valid && !m_ready;
    stall_v = {m_data, m_user, m_last};
    if (m_valid && m_ready && e) begin
      if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
      else check("out_pixel", {6'd0, m_data, m_user, m_last}, {6'd0, exp_q.pop_front()});
    end
    if (v && s_ready) begin
      exp_q.push_back({expd, u, l});
      xlog.push_back(wave_x);
      phlog.push_back(wave_phase);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bubble(input int n);
    repeat (n) cycle(1'b0, 24'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 24'h0);
  endtask

  task automatic reset_dut();
    #2 rst_n = 1'b0;
    #1 check("rst_mvalid", {31'd0, m_valid}, 32'd0);
    exp_q.delete();
    stall_p = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] x_exp [8]  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd0};
  logic [15:0] steps [2]  = '{16'h0100, 16'h8000};
  logic [15:0] ph_exp [6] = '{16'h0000, 16'h0100, 16'h0200, 16'h0000, 16'h8000, 16'h0000};
  logic [23:0] kt_px [5]  = '{24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'h010203, 24'hC8C8C8};
  logic [15:0] kt_k [5]   = '{16'h7FFF, 16'h8000, 16'h0000, 16'h4000, 16'hC000};
  logic [23:0] kt_e [5]   = '{24'hFF00FF, 24'h000000, 24'h000000, 24'h010102, 24'h000000};

  initial begin
    int lat;
    int n;
    logic        e, mr;
    logic [23:0] d;
    logic [15:0] k;

    en = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {8'd0, m_data}, 32'd0);
    check("rst_m_user", {31'd0, m_user}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_wave_en", {31'd0, wave_en}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // latency and basic scaling
    cycle(1'b1, 24'hC8C8C8, 1'b1, 1'b1, 16'h4000, 1'b1, 1'b1, 24'h646464);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      bubble(1);
      if (m_valid && lat == 0) lat = i + 1;
    end
    check("latency", lat, 32'd14);
    check("drain_lat", exp_q.size(), 32'd0);

    // x coordinate sequence
    xlog.delete();
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 24'h123456, i == 7, i == 3, 16'h0, 1'b1, 1'b1, 24'h0);
    bubble(16);
    check("x_count", xlog.size(), 32'd8);
    for (int i = 0; i < 8 && i < xlog.size(); i++) check("wave_x", {16'd0, xlog[i]}, {16'd0, x_exp[i]});

    // per-frame phase
    for (int s = 0; s < 2; s++) begin
      reset_dut();
      phase_step = steps[s];
      phlog.delete();
      for (int i = 0; i < 3; i++) cycle(1'b1, 24'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 24'h0);
      bubble(1);
      check("ph_count", phlog.size(), 32'd3);
      for (int i = 0; i < 3 && i < phlog.size(); i++)
        check("wave_phase", {16'd0, phlog[i]}, {16'd0, ph_exp[s*3+i]});
    end

    // coefficient boundaries
    reset_dut();
    phase_step = 16'h0;
    for (int i = 0; i < 5; i++) cycle(1'b1, kt_px[i], 1'b0, 1'b0, kt_k[i], 1'b1, 1'b1, kt_e[i]);
    bubble(16);
    check("drain_koef", exp_q.size(), 32'd0);

    // random stream with stalls and enable toggling
    reset_dut();
    phase_step = 16'h1234;
    for (int i = 0; i < 300; i++) begin
      e  = ($urandom_range(0, 9) != 0);
      mr = e && !(i >= 100 && i < 105) && ($urandom_range(0, 3) != 0);
      d  = 24'($urandom);
      k  = 16'($urandom);
      cycle(1'($urandom_range(0, 1)), d, i % 50 == 0, i % 10 == 9, k, mr, e, ref_scale(d, k));
    end
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      bubble(1);
      n++;
    end
    check("drain_rand", exp_q.size(), 32'd0);

    // reset with pixels in flight
    phase_step = 16'h0300;
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 24'hABCDEF, i == 0 || i == 5, 1'b0, 16'h4000, 1'b1, 1'b1, 24'h0);
    reset_dut();
    bubble(20);
    check("post_rst_idle", {31'd0, m_valid}, 32'd0);
    xlog.delete();
    phlog.delete();
    cycle(1'b1, 24'h808080, 1'b1, 1'b0, 16'h4000, 1'b1, 1'b1, 24'h404040);
    check("rst_sof_x", xlog.size() > 0 ? {16'd0, xlog[0]} : 32'hFFFF_FFFF, 32'd0);
    check("rst_sof_phase", phlog.size() > 0 ? {16'd0, phlog[0]} : 32'hFFFF_FFFF, 32'd0);
    bubble(16);
    check("drain_rst", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_pixel_modulator.md
Name: wave_pixel_modulator

Overview:
- Streaming pixel stage directly downstream of horizontal_wave.
- Accepts a 24-bit RGB video stream and generates, per pixel, the x coordinate and per-frame phase that drive horizontal_wave.
- Holds each pixel in a delay line matched to the wave latency, then scales each colour channel by the returned Q1.15 coefficient.
- Output is a valid/ready stream with SOF/EOL sidebands, placed between the video source and the display/output formatter.

Parameters:
- WAVE_LATENCY, 13, number of wave_en-qualified cycles from presenting wave_x/wave_phase to the matching wave_koef (horizontal_wave STAGES + 3).
- CH_WIDTH, 8, bits per colour channel; 3 channels packed {R,G,B}.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  global enable; 0 freezes all state
- phase_step  in  16  signed per-frame phase increment, wraps mod 2^16
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid & s_ready
- s_data  in  3*CH_WIDTH  input pixel {R,G,B}
- s_user  in  1  start of frame, first pixel
- s_last  in  1  end of line
- wave_en  out  1  enable to horizontal_wave
- wave_x  out  16  x coordinate to horizontal_wave
- wave_phase  out  16  signed phase to horizontal_wave
- wave_koef  in  16  signed Q1.15 coefficient from horizontal_wave
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  3*CH_WIDTH  scaled pixel
- m_user  out  1  SOF, delayed with its pixel
- m_last  out  1  EOL, delayed with its pixel

Behaviour:
- Reset (rst_n low, async):
  - m_valid, m_data, m_user, m_last = 0.
  - All delay-line valid bits = 0.
  - x counter = 0, phase_acc = 0, first_frame = 1.
  - Takes effect immediately, including mid-frame; data in flight is discarded.
- Pipeline advance:
  - advance = en & (m_ready | ~m_valid).
  - s_ready = advance; wave_en = advance.
  - Every register advances only on advance, including bubble slots. The valid bit of a slot = s_valid & s_ready at entry.
  - en=0: s_ready=0, wave_en=0, all state held, m_* held.
- Coordinate generation (combinational, for the pixel currently at the input):
  - wave_x = 0 if s_user=1, else the x counter.
  - On accept: x counter <= 0 if s_last, else wave_x + 1 (wraps mod 2^16).
- Phase generation:
  - Frame N (counting from 0 after reset) uses phase N*phase_step mod 2^16.
  - On an accepted s_user pixel:
    - first_frame=1: clear first_frame; phase_acc unchanged.
    - Otherwise: phase_acc <= phase_acc + phase_step, and wave_phase for that same pixel = phase_acc + phase_step (combinational).
  - All other cycles: wave_phase = phase_acc.
- Delay line:
  - WAVE_LATENCY slots carry {valid, data, user, last}.
  - The slot exiting aligns with wave_koef for that pixel.
- Scaling register:
  - Loaded on advance from the delay-line head.
  - Per channel: p = ch * koef, signed, at least CH_WIDTH+17 bits; r = (p + 2^14) >>> 15.
  - If koef < 0: r = 0. If r > 2^CH_WIDTH-1: saturate to 2^CH_WIDTH-1.
  - m_valid/m_user/m_last take the head slot's bits.
- Latency: WAVE_LATENCY+1 advancing cycles from accept to m_valid (14 at defaults, with no stall).
- Ordering:
  - No pixel dropped, duplicated or reordered.
  - m_data/m_user/m_last held stable while m_valid & ~m_ready.
- Throughput: 1 pixel/cycle when m_ready stays high.
- Simultaneous s_user & s_last on one pixel: x=0 for that pixel, counter reset to 0, phase updated as for SOF.

Test Plan:
- Bench models horizontal_wave as a WAVE_LATENCY-deep wave_en-qualified delay of a stimulus koef.
- Constant koef 0x4000, pixel 0xC8C8C8 accepted at cycle t -> m_valid at t+14 with m_data 0x646464.
- Line of 4 pixels (last on 4th), then 3 pixels, then SOF pixel -> wave_x 0,1,2,3,0,1,2,0.
- phase_step 0x0100, three SOF pixels -> wave_phase 0x0000, 0x0100, 0x0200. phase_step 0x8000 -> 0x0000, 0x8000, 0x0000.
- koef 0x7FFF with pixel 0xFF00FF -> 0xFF00FF. koef 0x8000 -> 0x000000. koef 0x0000 -> 0x000000.
- Random stream with random m_ready (hold low 5 cycles mid-frame) and en toggling:
  - Output sequence equals the reference model.
  - m_* stable during stall.
  - s_ready=0 whenever en=0.
- rst_n asserted mid-frame with 10 pixels in flight:
  - m_valid=0 at once, nothing emitted afterwards from old data.
  - Next SOF uses phase 0x0000 and x 0.
